stop_it_rand_delay: RTL and testbench

//  Random-delay timer for the stop-it game, directly downstream of the 5-bit LFSR.
//  On start_i it pulses next_o to advance the LFSR, then samples rand_i one cycle later.
//  It then waits (rand_i + MIN_TICKS) prescaled ticks and pulses done_o.
//  The game FSM uses done_o to time the unpredictable "go" moment.

---
 rtl/stop_it_rand_delay_if.sv | 24 ++
 rtl/stop_it_rand_delay.sv | 94 +++++++++
 tb/tb_stop_it_rand_delay.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/stop_it_rand_delay_if.sv
// Handshake bundle between the stop-it game FSM, the LFSR and the random-delay timer.
interface stop_it_rand_delay_if #(
  parameter int RAND_W = 5
);
  logic              start_i;
  logic              abort_i;
  logic [RAND_W-1:0] rand_i;
  logic              next_o;
  logic              busy_o;
  logic              done_o;
  logic [RAND_W:0]   remaining_o;

  // Requester side: game FSM plus the LFSR value feed
  modport master (
    output start_i, abort_i, rand_i,
    input  next_o, busy_o, done_o, remaining_o
  );

  // Timer side
  modport slave (
    input  start_i, abort_i, rand_i,
    output next_o, busy_o, done_o, remaining_o
  );
endinterface

// File: rtl/stop_it_rand_delay.sv
// Random-delay timer: advances the LFSR, samples its new value, then counts
// (rand_i + MIN_TICKS) prescaled ticks before a single done_o pulse.
//
// state   | meaning
// IDLE    | waiting for start_i
// ADVANCE | next_o high, LFSR steps on the closing edge
// LOAD    | rand_i valid, load tick counter
// WAIT    | counting prescaled ticks
// DONE    | done_o high for one cycle
module stop_it_rand_delay #(
  parameter int RAND_W    = 5,
  parameter int TICK_DIV  = 4,
  parameter int MIN_TICKS = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  stop_it_rand_delay_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADVANCE = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // A one-bit prescaler is kept even when TICK_DIV==1 so the compare stays legal.
  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [RAND_W:0] MIN_W      = (RAND_W + 1)'(MIN_TICKS);
  localparam logic [RAND_W:0] ONE_W      = (RAND_W + 1)'(1);

  logic [2:0]      state_q;
  logic [RAND_W:0] ticks_q;
  logic [PW-1:0]   presc_q;
  logic            tick;

  assign tick = (presc_q == PRESC_LAST);

  // Sequencer, tick counter and prescaler; abort wins over a coincident tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ticks_q <= '0;
      presc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.abort_i) state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          state_q <= bus.abort_i ? S_IDLE : S_LOAD;
        end
        S_LOAD: begin
          presc_q <= '0;
          if (bus.abort_i) begin
            state_q <= S_IDLE;
            ticks_q <= '0;
          end else begin
            state_q <= S_WAIT;
            ticks_q <= {1'b0, bus.rand_i} + MIN_W;
          end
        end
        S_WAIT: begin
          if (bus.abort_i) begin
            state_q <= S_IDLE;
            ticks_q <= '0;
            presc_q <= '0;
          end else if (tick) begin
            presc_q <= '0;
            ticks_q <= ticks_q - ONE_W;
            if (ticks_q == ONE_W) state_q <= S_DONE;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ticks_q <= '0;
          presc_q <= '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from state
  assign bus.next_o      = (state_q == S_ADVANCE);
  assign bus.busy_o      = (state_q == S_ADVANCE) || (state_q == S_LOAD) || (state_q == S_WAIT);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.remaining_o = ticks_q;

endmodule

// File: tb/tb_stop_it_rand_delay.sv
// Bench for stop_it_rand_delay: event-time model checked every cycle plus directed literals.
module tb_stop_it_rand_delay;
  localparam int RW = 5;
  localparam int TD = 4;
  localparam int MT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          use_lfsr = 1'b0;
  logic [RW-1:0] rand_stub = '0;
  logic [RW-1:0] lfsr_q;

  stop_it_rand_delay_if #(.RAND_W(RW)) bus ();

  stop_it_rand_delay #(.RAND_W(RW), .TICK_DIV(TD), .MIN_TICKS(MT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.rand_i = use_lfsr ? lfsr_q : rand_stub;

  // Real LFSR stand-in, stepped by next_o
  always @(posedge clk) begin
    if (rst) lfsr_q <= 5'h01;
    else if (bus.next_o) lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  end

  function automatic int gold(input int k);
    logic [4:0] v;
    v = 5'h01;
    for (int i = 0; i < k; i++) v = {v[3:0], v[4] ^ v[2]};
    return int'(v);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the timer is either idle or d edges past its accepted start edge.
  int cyc = 0;
  int act_m = 0;
  int d = 0;
  int n = 0;
  int next_cnt = 0;
  int done_cnt = 0;
  int e_next, e_busy, e_done, e_rem;

  always @(posedge clk) begin
    cyc++;
    if (rst) act_m = 0;
    else if (act_m != 0) begin
      d++;
      if (d == 2 && !bus.abort_i) n = int'(bus.rand_i) + MT;
      if (bus.abort_i && (d <= 2 || d <= TD * n + 2)) act_m = 0;
      else if (d == TD * n + 3) act_m = 0;
    end else if (bus.start_i && !bus.abort_i) begin
      act_m = 1;
      d = 0;
    end
    #1;
    e_next = 0; e_busy = 0; e_done = 0; e_rem = 0;
    if (act_m != 0) begin
      if (d == 0) begin e_next = 1; e_busy = 1; end
      else if (d == 1) e_busy = 1;
      else if (d <= TD * n + 1) begin e_busy = 1; e_rem = n - (d - 2) / TD; end
      else e_done = 1;
    end
    check("model next", int'(bus.next_o), e_next);
    check("model busy", int'(bus.busy_o), e_busy);
    check("model done", int'(bus.done_o), e_done);
    check("model remaining", int'(bus.remaining_o), e_rem);
    if (bus.next_o) next_cnt++;
    if (bus.done_o) done_cnt++;
  end

  int e0 = 0;

  task automatic run_to(input int e);
    while (cyc - e0 < e) @(negedge clk);
  endtask

  task automatic start_pulse(input logic [RW-1:0] r);
    rand_stub = r;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int nc, dc;

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // 1. reset
    check("reset next", int'(bus.next_o), 0);
    check("reset busy", int'(bus.busy_o), 0);
    check("reset done", int'(bus.done_o), 0);
    check("reset remaining", int'(bus.remaining_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // 2. basic wait, rand 5 -> N=7
    nc = next_cnt; dc = done_cnt;
    start_pulse(5'd5);
    check("t2 next at 0", int'(bus.next_o), 1);
    run_to(1);  check("t2 next at 1", int'(bus.next_o), 0);
    run_to(2);  check("t2 rem at 2", int'(bus.remaining_o), 7);
    run_to(6);  check("t2 rem at 6", int'(bus.remaining_o), 6);
    run_to(29); check("t2 done at 29", int'(bus.done_o), 0);
    run_to(30); check("t2 done at 30", int'(bus.done_o), 1);
                check("t2 busy at 30", int'(bus.busy_o), 0);
    run_to(31); check("t2 done at 31", int'(bus.done_o), 0);
    check("t2 next count", next_cnt - nc, 1);
    check("t2 done count", done_cnt - dc, 1);

    // 3. extremes
    start_pulse(5'd0);
    run_to(9);  check("t3a done at 9", int'(bus.done_o), 0);
    run_to(10); check("t3a done at 10", int'(bus.done_o), 1);
    run_to(12);
    start_pulse(5'd31);
    run_to(2);   check("t3b rem at 2", int'(bus.remaining_o), 33);
    run_to(133); check("t3b done at 133", int'(bus.done_o), 0);
    run_to(134); check("t3b done at 134", int'(bus.done_o), 1);
    run_to(136);

    // 4. abort in WAIT, ignored start
    nc = next_cnt; dc = done_cnt;
    start_pulse(5'd5);
    run_to(7);  bus.start_i = 1'b1;
    run_to(8);  bus.start_i = 1'b0;
    run_to(14); bus.abort_i = 1'b1;
    run_to(15); bus.abort_i = 1'b0;
    check("t4 rem after abort", int'(bus.remaining_o), 0);
    check("t4 busy after abort", int'(bus.busy_o), 0);
    run_to(55);
    check("t4 no done", done_cnt - dc, 0);
    check("t4 next count", next_cnt - nc, 1);

    // 5. start&abort in IDLE, start during DONE
    nc = next_cnt; dc = done_cnt;
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    @(negedge clk);
    check("t5 busy after start&abort", int'(bus.busy_o), 0);
    check("t5 next after start&abort", next_cnt - nc, 0);
    start_pulse(5'd0);
    run_to(10); check("t5 done at 10", int'(bus.done_o), 1);
    bus.start_i = 1'b1;
    run_to(11); bus.start_i = 1'b0;
    check("t5 done at 11", int'(bus.done_o), 0);
    run_to(13);
    check("t5 busy after DONE start", int'(bus.busy_o), 0);
    check("t5 next count", next_cnt - nc, 1);
    check("t5 done count", done_cnt - dc, 1);

    // 6. mid-operation reset, then real LFSR
    start_pulse(5'd5);
    run_to(11); rst = 1'b1;
    run_to(12); rst = 1'b0;
    check("t6 rst busy", int'(bus.busy_o), 0);
    check("t6 rst next", int'(bus.next_o), 0);
    check("t6 rst done", int'(bus.done_o), 0);
    check("t6 rst remaining", int'(bus.remaining_o), 0);
    @(negedge clk);
    use_lfsr = 1'b1;
    start_pulse(5'd0);
    run_to(2);
    check("t6 first capture", int'(bus.remaining_o), gold(1) + MT);
    check("t6 first literal", int'(bus.remaining_o), 4);
    run_to(TD * (gold(1) + MT) + 4);
    start_pulse(5'd0);
    run_to(2);
    check("t6 second capture", int'(bus.remaining_o), gold(2) + MT);
    check("t6 second literal", int'(bus.remaining_o), 6);
    run_to(TD * (gold(2) + MT) + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
